// File: rtl/eff_noise_gate.sv
// Noise gate ahead of the hard-clip stage: closed/attack/open/hold/release envelope ramps per-sample gain 0..unity.
// Latency 2 cycles at 1 sample/cycle; no backpressure, vld_i gaps freeze the envelope; en=0 is a plain 2-cycle bypass.
module eff_noise_gate #(
    parameter int DATA_WIDTH   = 8,
    parameter int GAIN_BITS    = 4,
    parameter int HOLD_SAMPLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic        [DATA_WIDTH-2:0] thresh,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         vld_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic                         gate_open
);
    localparam int GW = GAIN_BITS + 1;
    localparam int CW = $clog2(HOLD_SAMPLES + 1);
    localparam int PW = DATA_WIDTH + GW;
    localparam logic [GW-1:0] UNITY     = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_CLOSED,
        S_ATTACK,
        S_OPEN,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t                        state, state_n;
    logic         [GW-1:0]         gain, gain_n, gain_up, gain_dn, gain_eff;
    logic         [CW-1:0]         cnt, cnt_n;
    logic         [DATA_WIDTH-1:0] mag;
    logic                          loud;
    logic signed  [DATA_WIDTH-1:0] d1;
    logic                          v1;
    logic                          loud1;
    logic signed  [PW-1:0]         prod;

    // Magnitude kept unsigned at full width so the most negative sample maps to 2^(DATA_WIDTH-1).
    always_comb begin
        mag  = data_i[DATA_WIDTH-1] ? (~data_i + 1'b1) : data_i;
        loud = mag > {1'b0, thresh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1    <= '0;
            v1    <= 1'b0;
            loud1 <= 1'b0;
        end else begin
            d1    <= data_i;
            v1    <= vld_i;
            loud1 <= loud;
        end
    end

    assign gain_eff = en ? gain : UNITY;
    assign prod     = PW'(d1) * PW'($signed({1'b0, gain_eff}));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= v1;
            if (v1)
                data_o <= DATA_WIDTH'(prod >>> GAIN_BITS);
        end
    end

    assign gain_up = gain + 1'b1;
    assign gain_dn = gain - 1'b1;

    always_comb begin
        state_n = state;
        gain_n  = gain;
        cnt_n   = cnt;
        if (!en) begin
            state_n = S_OPEN;
            gain_n  = UNITY;
            cnt_n   = '0;
        end else if (v1) begin
            case (state)
                S_CLOSED: begin
                    if (loud1) begin
                        state_n = S_ATTACK;
                        gain_n  = GW'(1);
                    end
                end
                S_ATTACK: begin
                    gain_n = gain_up;
                    if (gain_up == UNITY)
                        state_n = S_OPEN;
                end
                S_OPEN: begin
                    if (!loud1) begin
                        if (HOLD_SAMPLES == 1) begin
                            state_n = S_RELEASE;
                        end else begin
                            state_n = S_HOLD;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (loud1) begin
                        state_n = S_OPEN;
                        cnt_n   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_n = S_RELEASE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Re-attack one step below unity lands on unity, so it goes straight to OPEN.
                    if (loud1) begin
                        gain_n  = gain_up;
                        state_n = (gain_up == UNITY) ? S_OPEN : S_ATTACK;
                    end else begin
                        gain_n = gain_dn;
                        if (gain_dn == '0)
                            state_n = S_CLOSED;
                    end
                end
                default: begin
                    state_n = S_CLOSED;
                    gain_n  = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLOSED;
            gain      <= '0;
            cnt       <= '0;
            gate_open <= 1'b0;
        end else begin
            state     <= state_n;
            gain      <= gain_n;
            cnt       <= cnt_n;
            gate_open <= (state_n == S_OPEN) || (state_n == S_HOLD);
        end
    end
endmodule

// File: tb/tb_eff_noise_gate.sv
// Directed bench for eff_noise_gate with DATA_WIDTH=8, GAIN_BITS=4, HOLD_SAMPLES=4.
module tb_eff_noise_gate;
    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic        [6:0] thresh;
    logic signed [7:0] data_i;
    logic              vld_i;
    logic signed [7:0] data_o;
    logic              vld_o;
    logic              gate_open;

    int errors = 0;
    int checks = 0;

    eff_noise_gate #(
        .DATA_WIDTH  (8),
        .GAIN_BITS   (4),
        .HOLD_SAMPLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .thresh   (thresh),
        .data_i   (data_i),
        .vld_i    (vld_i),
        .data_o   (data_o),
        .vld_o    (vld_o),
        .gate_open(gate_open)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; thresh = 7'd10; vld_i = 1'b0; data_i = 8'sd0;
        tick; tick;
        rst = 1'b0;
        checks++; if (vld_o !== 1'b0)      begin errors++; $display("FAIL reset_vld got=%b exp=0", vld_o); end
        checks++; if (data_o !== 8'sd0)    begin errors++; $display("FAIL reset_data got=%0d exp=0", data_o); end
        checks++; if (gate_open !== 1'b0)  begin errors++; $display("FAIL reset_gate got=%b exp=0", gate_open); end
        for (int i = 0; i <= 8; i++) begin
            vld_i = (i < 8); data_i = 8'sd5;
            tick;
            checks++; if (vld_o !== (i >= 1)) begin errors++; $display("FAIL quiet_vld[%0d] got=%b exp=%b", i, vld_o, (i >= 1)); end
            checks++; if (data_o !== 8'sd0)   begin errors++; $display("FAIL quiet_data[%0d] got=%0d exp=0", i, data_o); end
            checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL quiet_gate[%0d] got=%b exp=0", i, gate_open); end
        end
    endtask

    task automatic test_attack;
        int dexp[18];
        dexp = '{0, 3, 6, 9, 12, 15, 18, 21, 25, 28, 31, 34, 37, 40, 43, 46, 50, 50};
        thresh = 7'd10;
        for (int i = 0; i <= 18; i++) begin
            vld_i = (i < 18); data_i = 8'sd50;
            tick;
            if (i >= 1) begin
                checks++; if (vld_o !== 1'b0 && vld_o !== 1'b1 || vld_o !== 1'b1) begin errors++; $display("FAIL attack_vld[%0d] got=%b exp=1", i-1, vld_o); end
                checks++; if (data_o !== 8'(dexp[i-1])) begin errors++; $display("FAIL attack_data[%0d] got=%0d exp=%0d", i-1, data_o, dexp[i-1]); end
                checks++; if (gate_open !== (i - 1 >= 15)) begin errors++; $display("FAIL attack_gate[%0d] got=%b exp=%b", i-1, gate_open, (i - 1 >= 15)); end
            end
        end
    endtask

    task automatic test_hold_release;
        int din[15];
        int dexp[15];
        logic gexp[15];
        din  = '{50, 0, 0, 0, 50, 0, 0, 0, 0, -32, -32, -32, -32, -32, -32};
        dexp = '{50, 0, 0, 0, 50, 0, 0, 0, 0, -32, -30, -28, -26, -24, -22};
        gexp = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        thresh = 7'd40;
        for (int i = 0; i <= 15; i++) begin
            vld_i = (i < 15); data_i = (i < 15) ? 8'(din[i]) : 8'sd0;
            tick;
            if (i >= 1) begin
                checks++; if (data_o !== 8'(dexp[i-1])) begin errors++; $display("FAIL hold_data[%0d] got=%0d exp=%0d", i-1, data_o, dexp[i-1]); end
                checks++; if (gate_open !== gexp[i-1])  begin errors++; $display("FAIL hold_gate[%0d] got=%b exp=%b", i-1, gate_open, gexp[i-1]); end
            end
        end
    endtask

    task automatic test_min_sample;
        int din[9];
        int dexp[9];
        din  = '{0, 0, 0, 0, 0, 0, 0, -128, 16};
        dexp = '{0, 0, 0, 0, 0, 0, 0, -24, 4};
        thresh = 7'd127;
        for (int i = 0; i <= 9; i++) begin
            vld_i = (i < 9); data_i = (i < 9) ? 8'(din[i]) : 8'sd0;
            tick;
            if (i >= 1) begin
                checks++; if (data_o !== 8'(dexp[i-1])) begin errors++; $display("FAIL minval_data[%0d] got=%0d exp=%0d", i-1, data_o, dexp[i-1]); end
                checks++; if (gate_open !== 1'b0)       begin errors++; $display("FAIL minval_gate[%0d] got=%b exp=0", i-1, gate_open); end
            end
        end
    endtask

    task automatic test_bypass;
        int din[6];
        int dexp[6];
        logic gexp[6];
        logic signed [7:0] held;
        logic signed [7:0] v;
        en = 1'b0; thresh = 7'd10;
        held = 8'sd4;
        for (int k = 0; k <= 9; k++) begin
            vld_i = (k % 2 == 0) && (k < 8);
            v = ((k / 2) % 2 == 0) ? 8'sd5 : -8'sd5;
            data_i = vld_i ? v : -8'sd99;
            tick;
            if (k >= 1) begin
                if (k % 2 == 1 && k < 9) held = (((k - 1) / 2) % 2 == 0) ? 8'sd5 : -8'sd5;
                checks++; if (vld_o !== (k % 2 == 1 && k < 9)) begin errors++; $display("FAIL bypass_vld[%0d] got=%b exp=%b", k, vld_o, (k % 2 == 1 && k < 9)); end
                checks++; if (data_o !== held)    begin errors++; $display("FAIL bypass_data[%0d] got=%0d exp=%0d", k, data_o, held); end
                checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL bypass_gate[%0d] got=%b exp=1", k, gate_open); end
            end
        end
        din  = '{5, 0, 0, 5, 5, 5};
        dexp = '{5, 0, 0, 5, 5, 4};
        gexp = '{1, 1, 1, 0, 0, 0};
        en = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            vld_i = (i < 6); data_i = (i < 6) ? 8'(din[i]) : 8'sd0;
            tick;
            if (i >= 1) begin
                checks++; if (data_o !== 8'(dexp[i-1])) begin errors++; $display("FAIL reenable_data[%0d] got=%0d exp=%0d", i-1, data_o, dexp[i-1]); end
                checks++; if (gate_open !== gexp[i-1])  begin errors++; $display("FAIL reenable_gate[%0d] got=%b exp=%b", i-1, gate_open, gexp[i-1]); end
            end
        end
    endtask

    task automatic test_rst_mid_attack;
        thresh = 7'd10; en = 1'b1; vld_i = 1'b0;
        rst = 1'b1; tick; rst = 1'b0;
        vld_i = 1'b1; data_i = 8'sd50;
        tick; tick; tick; tick;
        checks++; if (data_o !== 8'sd6) begin errors++; $display("FAIL preattack_data got=%0d exp=6", data_o); end
        rst = 1'b1; tick; rst = 1'b0;
        checks++; if (vld_o !== 1'b0)     begin errors++; $display("FAIL midrst_vld0 got=%b exp=0", vld_o); end
        checks++; if (data_o !== 8'sd0)   begin errors++; $display("FAIL midrst_data0 got=%0d exp=0", data_o); end
        checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL midrst_gate got=%b exp=0", gate_open); end
        tick;
        checks++; if (vld_o !== 1'b0)     begin errors++; $display("FAIL midrst_vld1 got=%b exp=0", vld_o); end
        checks++; if (data_o !== 8'sd0)   begin errors++; $display("FAIL midrst_data1 got=%0d exp=0", data_o); end
        tick;
        checks++; if (vld_o !== 1'b1)     begin errors++; $display("FAIL midrst_vld2 got=%b exp=1", vld_o); end
        checks++; if (data_o !== 8'sd0)   begin errors++; $display("FAIL midrst_first got=%0d exp=0", data_o); end
        tick;
        checks++; if (data_o !== 8'sd3)   begin errors++; $display("FAIL midrst_second got=%0d exp=3", data_o); end
        vld_i = 1'b0;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_attack;
        test_hold_release;
        test_min_sample;
        test_bypass;
        test_rst_mid_attack;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eff_noise_gate.md
Name: eff_noise_gate

Overview:
- Noise gate stage placed directly upstream of the hard-clip distortion in the effect chain.
- Attenuates low-level hiss before clip gain amplifies it.
- Signed PCM samples arrive with a valid strobe. An envelope FSM (closed/attack/open/hold/release) ramps a per-sample gain between 0 and unity.
- When disabled, the block is a fixed-latency bypass.

Parameters:
- DATA_WIDTH, 8: sample width, signed two's complement.
- GAIN_BITS, 4: gain fraction bits; unity gain = 2^GAIN_BITS. Attack and release each take 2^GAIN_BITS valid samples.
- HOLD_SAMPLES, 256: consecutive quiet valid samples, at full gain, before release starts. Must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  gate enable; 0 = bypass.
- thresh  in  DATA_WIDTH-1  unsigned open threshold, compared against |sample|.
- data_i  in  DATA_WIDTH  signed input sample.
- vld_i  in  1  input sample valid.
- data_o  out  DATA_WIDTH  signed gated sample.
- vld_o  out  1  output valid.
- gate_open  out  1  high when state is OPEN or HOLD.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - data_o=0, vld_o=0, gate_open=0.
  - state=CLOSED, gain=0, hold count=0.
  - Pipeline registers=0.
- Pipeline, 2 cycles:
  - Stage 1 registers d1=data_i, v1=vld_i, loud1=(|data_i| > thresh).
  - |x| is computed in DATA_WIDTH unsigned bits, so the most negative value gives 2^(DATA_WIDTH-1). thresh is zero-extended.
  - Stage 2: when v1=1, data_o <= (d1 * gain) >>> GAIN_BITS.
  - The product is signed at full width, arithmetic shift (floor), truncated to DATA_WIDTH. No overflow is possible since gain <= unity.
  - When v1=0, data_o holds its value.
  - vld_o = vld_i delayed exactly 2 cycles, independent of en and state.
- Gain applied to a sample is the value before that sample's FSM update. The FSM and gain update only on cycles with v1=1, using loud1.
- State transitions (each on a valid sample):
  - CLOSED:
    - loud: -> ATTACK, gain <= 1.
    - quiet: stay, gain = 0.
  - ATTACK: gain <= gain+1 on every sample, loud or quiet. When the new gain equals 2^GAIN_BITS -> OPEN.
  - OPEN, gain = 2^GAIN_BITS:
    - loud: stay.
    - quiet: if HOLD_SAMPLES==1 -> RELEASE, else -> HOLD with count <= 1.
  - HOLD:
    - loud: -> OPEN, count <= 0.
    - quiet: if count == HOLD_SAMPLES-1 -> RELEASE, count <= 0; else count++.
  - RELEASE:
    - loud: -> ATTACK, gain <= gain+1.
    - quiet: gain <= gain-1; if the new gain is 0 -> CLOSED.
- en=0, evaluated every cycle regardless of valid:
  - state <= OPEN, gain <= 2^GAIN_BITS, count <= 0.
  - Samples pass unchanged with 2-cycle latency.
  - Re-enabling therefore starts OPEN, with no ramp artefact.
- gate_open is registered and follows the state register.
- rst mid-stream: all state is cleared. vld_o is 0 for 2 cycles after rst deasserts, even if vld_i is high. The gate restarts CLOSED (when en=1).
- Back-to-back valids on every cycle are supported; throughput is 1 sample per cycle.
- Gaps in vld_i freeze the FSM, gain and count.

Test Plan (DATA_WIDTH=8, GAIN_BITS=4, HOLD_SAMPLES=4, thresh=10, en=1 unless stated):
- Reset, then 8 valid samples of +5.
  -> vld_o high 2 cycles after each vld_i; data_o=0 throughout; gate_open=0.
- From CLOSED, 18 valid samples of +50.
  -> outputs 0,3,6,9,12,15,18,21,25,28,31,34,37,40,43,46,50,50.
  -> gate_open rises when gain reaches 16.
- From OPEN: +50, then 0,0,0, then +50, then 0,0,0,0, then six samples of -32.
  -> the first burst of zeros re-opens with no attenuation.
  -> after the 4th consecutive quiet sample, state=RELEASE.
  -> -32 outputs -32,-30,-28,-26,-24,-22 (floor shift), gain decrementing from 16.
- Ramp RELEASE down to gain 3, then apply -128.
  -> output floor(-128*3/16) = -24; state -> ATTACK, gain=4.
  -> thresh=127 still treats -128 (|x|=128) as loud.
- en=0 with alternating +5/-5 and vld_i toggling every other cycle.
  -> data_o exact copy delayed 2 cycles.
  -> after en returns to 1, a +5 sample outputs +5 (OPEN) and then enters HOLD.
- Assert rst for 1 cycle mid-attack while vld_i is held high.
  -> vld_o=0 and data_o=0 for 2 cycles; state CLOSED; the next loud sample outputs 0, then 3.
